// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and frame constants.
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_if.sv
// Receiver-side bundle: serial line in, received byte and status strobes out.
interface uart_rx_sync_if;
  import uart_pkg::*;

  logic                      rx;
  logic [UART_DATA_BITS-1:0] data_out;
  logic                      data_valid;
  logic                      frame_err;
  logic                      busy;

  modport master (
    input  rx,
    output data_out,
    output data_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset level is a parameter
// so idle-high lines do not see a false edge when reset releases.
module sync_2ff
  import uart_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [UART_SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= {UART_SYNC_STAGES{RST_VAL}};
    end else begin
      ff <= {ff[UART_SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[UART_SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_sync.sv
// 8N1 UART receiver: synchronised rx, mid-bit sampling, one-cycle valid / framing-error strobes.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | counting to mid start bit to reject glitches
// DATA  | sampling 8 data bits LSB first, one per bit period
// STOP  | waiting for mid stop bit; high = good frame, low = framing error
// BREAK | line stuck low after a framing error; wait for it to return high
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 9600
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_sync_if.master bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx_sync: CLK_FREQ/BAUD must be at least 4");
  end

  logic                      rx_s;
  rx_state_t                 state,     state_nxt;
  logic [CNT_W-1:0]          cnt,       cnt_nxt;
  logic [IDX_W-1:0]          idx,       idx_nxt;
  logic [UART_DATA_BITS-1:0] shift,     shift_nxt;
  logic [UART_DATA_BITS-1:0] data_q,    data_nxt;
  logic                      valid_q,   valid_nxt;
  logic                      err_q,     err_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shift   <= shift_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  // Baud counter restarts from zero whenever a state (or data bit) begins.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    shift_nxt = shift;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_s;
          if (idx == IDX_LAST) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: doc/uart_rx_sync.md
Name: uart_rx_sync

Overview:
Serial UART receiver for the sum/latch system. It sits directly upstream of the sum/latch datapath inside tt_um_top and is driven from ui_in[0].
- Synchronises the asynchronous rx line and detects 8N1 frames.
- Delivers each received byte with a one-cycle valid strobe.
- Flags framing errors so the latch stage can discard bad operands.

Parameters:
- CLK_FREQ, 10_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- CLKS_PER_BIT is a derived localparam = CLK_FREQ/BAUD (integer division); CLKS_PER_BIT >= 4 is required.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  asynchronous serial input; idle high.
- data_out  out  8  last correctly received byte; holds until the next good frame.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - data_out = 8'h00; data_valid = 0; frame_err = 0; busy = 0.
  - Synchroniser flops = 1 (idle level).
  - FSM = IDLE; bit counter = 0; baud counter = 0.
- Synchroniser: 2 flops on rx, giving rx_s. All decisions use rx_s only, so there are 2 cycles of input latency.
- Baud counter: counts 0..CLKS_PER_BIT-1. It is cleared on every state entry.
- FSM states and transitions:
  - IDLE: busy=0. rx_s==0 -> START.
  - START: wait until baud counter reaches (CLKS_PER_BIT-1)/2 (mid start bit), then resample.
    - rx_s==0 -> DATA, bit index 0.
    - rx_s==1 -> IDLE (glitch rejected; no strobe).
  - DATA: sample rx_s at every CLKS_PER_BIT count into shift register bit [index], LSB first.
    - After index 7 is sampled -> STOP.
  - STOP: sample rx_s after CLKS_PER_BIT counts (mid stop bit).
    - rx_s==1 -> on the next clock edge data_out <= shift register, data_valid=1 for exactly one cycle; then IDLE.
    - rx_s==0 -> frame_err=1 for one cycle; data_out unchanged; then BREAK.
  - BREAK: wait for rx_s==1, then IDLE. A held-low line (break condition) therefore produces exactly one frame_err and no spurious frames.
- busy is high in START, DATA, STOP and BREAK.
- data_valid and frame_err are never asserted in the same cycle.
- Back-to-back frames: the FSM is in IDLE from mid stop bit onward, so a start edge arriving immediately after the stop bit is caught.
- Reset mid-frame: all state returns to reset values immediately. The partial byte is discarded and no strobe is generated.
- The shift register is not visible externally. data_out changes only together with data_valid.
- No FIFO: the consumer must take the byte within one frame time, or it is overwritten by the next good frame.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum rx_state_t {IDLE, START, DATA, STOP, BREAK}.
  - Constants UART_DATA_BITS=8 and UART_SYNC_STAGES=2.
- One sub-module is natural: sync_2ff (a 1-bit two-flop synchroniser with parameterised reset value). The same sub-module is reused for other ui_in inputs.
- Everything else stays in uart_rx_sync.

Test Plan:
All scenarios use CLK_FREQ=1_000_000 and BAUD=62_500, giving CLKS_PER_BIT=16.
1. Reset, then send byte 8'hA5 with a valid stop bit -> exactly one data_valid pulse, data_out=8'hA5, frame_err never high. busy rises within 3 cycles of the start edge and falls by the end of the stop bit.
2. Back-to-back frames 8'h00, 8'hFF, 8'h3C with no idle gap -> three data_valid pulses in order with data_out 00, FF, 3C. Pulse spacing is 160 clocks ±1.
3. rx low pulse of 4 clocks, then high -> no data_valid, no frame_err. busy returns to 0 by clock 12 after the edge.
4. Frame 8'h55 with stop bit driven 0, then rx held low 100 clocks, then high -> one frame_err pulse and no data_valid. data_out keeps its previous value. A following good 8'h12 is received correctly.
5. Assert rst_n=0 during data bit 4 of 8'hC3, release, then send 8'h81 -> no strobe for the aborted frame. data_out=8'h00 after reset, then 8'h81 with a single data_valid.
6. Send 8'h96 with the bit period stretched to 17 clocks (≈+6% baud error) -> data_out=8'h96, data_valid pulse, no frame_err.
